// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4-subset responder backed by a 64-bit register-array SRAM. It serves as
// the simulation memory model and as the on-chip scratch RAM. The write path
// (AW/W/B) and the read path (AR/R) are independent FSMs over a 1R1W array,
// so they run fully concurrently with no cross-channel ordering.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   axi_aw_*              write address: addr, len (beats-1), size, burst
//   axi_w_*               write data: data, strb (byte enables), last
//   axi_b_*               write response: resp
//   axi_ar_*              read address: addr, len, size, burst
//   axi_r_*               read data: data (full word), resp, last
//
// Bursts: FIXED keeps the address, INCR steps +8 aligned down to 8, WRAP steps
// +8 inside a (len+1)*8-byte aligned window. A bad burst/size (burst=11,
// size>3, WRAP with len outside {1,3,7,15}) answers SLVERR and steps as INCR.
// Out-of-range beats answer DECERR; writes to them are dropped and reads
// return zero.
//
// Write FSM
//   state  | meaning
//   W_IDLE | aw_ready high, waiting for a write address
//   W_DATA | w_ready high, accepting exactly len+1 beats
//   W_RESP | b_valid high with the sticky response until b_ready
//
// Read FSM
//   state  | meaning
//   R_IDLE | ar_ready high, waiting for a read address
//   R_DATA | r_valid high, current beat held until r_ready
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned                AXI_DATA_WIDTH = 64,
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_BASE       = 32'h8000_0000,
    parameter int unsigned                MEM_DEPTH      = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          axi_aw_valid_i,
    output logic                          axi_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_i,
    input  logic [7:0]                    axi_aw_len_i,
    input  logic [2:0]                    axi_aw_size_i,
    input  logic [1:0]                    axi_aw_burst_i,

    input  logic                          axi_w_valid_i,
    output logic                          axi_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_i,
    input  logic                          axi_w_last_i,

    output logic                          axi_b_valid_o,
    input  logic                          axi_b_ready_i,
    output logic [1:0]                    axi_b_resp_o,

    input  logic                          axi_ar_valid_i,
    output logic                          axi_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
    input  logic [7:0]                    axi_ar_len_i,
    input  logic [2:0]                    axi_ar_size_i,
    input  logic [1:0]                    axi_ar_burst_i,

    output logic                          axi_r_valid_o,
    input  logic                          axi_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     axi_r_data_o,
    output logic [1:0]                    axi_r_resp_o,
    output logic                          axi_r_last_o
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;

    localparam addr_t MEM_BYTES = addr_t'(MEM_DEPTH * 8);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // -----------------------------------------------------------------------
    // Address helpers
    // -----------------------------------------------------------------------
    function automatic logic in_range(input addr_t a);
        // Subtract first so that MEM_BASE+MEM_BYTES never has to be formed.
        return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
        return IDX_W'((a - MEM_BASE) >> 3);
    endfunction

    function automatic logic bad_burst(input logic [7:0] len,
                                       input logic [1:0] burst,
                                       input logic [2:0] size);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (size > 3'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic addr_t next_addr(input addr_t      a,
                                        input logic [7:0] len,
                                        input logic [1:0] burst,
                                        input logic       bad);
        addr_t incr;
        addr_t mask;
        incr = (a & ~addr_t'(7)) + addr_t'(8);
        // (len+1)*8-1 == len*8+7; only meaningful for the legal wrap lengths.
        mask = addr_t'({len, 3'b111});
        if (bad) begin
            return incr;
        end
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | (incr & mask);
            default:     return incr;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Storage (not reset)
    // -----------------------------------------------------------------------
    logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Write channel
    // -----------------------------------------------------------------------
    w_state_t   w_state_q, w_state_d;
    addr_t      aw_addr_q, aw_addr_d;
    logic [7:0] aw_len_q, aw_len_d;
    logic [1:0] aw_burst_q, aw_burst_d;
    logic       aw_bad_q, aw_bad_d;
    logic [7:0] w_cnt_q, w_cnt_d;
    logic       w_slverr_q, w_slverr_d;
    logic       w_decerr_q, w_decerr_d;
    logic [1:0] b_resp_q, b_resp_d;
    logic       mem_we;
    logic       w_final_beat;

    always_comb begin
        w_state_d    = w_state_q;
        aw_addr_d    = aw_addr_q;
        aw_len_d     = aw_len_q;
        aw_burst_d   = aw_burst_q;
        aw_bad_d     = aw_bad_q;
        w_cnt_d      = w_cnt_q;
        w_slverr_d   = w_slverr_q;
        w_decerr_d   = w_decerr_q;
        b_resp_d     = b_resp_q;
        mem_we       = 1'b0;
        w_final_beat = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (axi_aw_valid_i) begin
                    aw_addr_d  = axi_aw_addr_i;
                    aw_len_d   = axi_aw_len_i;
                    aw_burst_d = axi_aw_burst_i;
                    aw_bad_d   = bad_burst(axi_aw_len_i, axi_aw_burst_i, axi_aw_size_i);
                    w_cnt_d    = 8'd0;
                    w_slverr_d = aw_bad_d;
                    w_decerr_d = 1'b0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_w_valid_i) begin
                    // The beat count, not w_last, decides where the burst ends.
                    w_final_beat = (w_cnt_q == aw_len_q);
                    mem_we       = in_range(aw_addr_q);
                    w_decerr_d   = w_decerr_q | ~mem_we;
                    w_slverr_d   = w_slverr_q | (axi_w_last_i != w_final_beat);
                    aw_addr_d    = next_addr(aw_addr_q, aw_len_q, aw_burst_q, aw_bad_q);
                    w_cnt_d      = w_cnt_q + 8'd1;
                    if (w_final_beat) begin
                        b_resp_d  = w_decerr_d ? RESP_DECERR :
                                    w_slverr_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_burst_q <= '0;
            aw_bad_q   <= 1'b0;
            w_cnt_q    <= '0;
            w_slverr_q <= 1'b0;
            w_decerr_q <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_burst_q <= aw_burst_d;
            aw_bad_q   <= aw_bad_d;
            w_cnt_q    <= w_cnt_d;
            w_slverr_q <= w_slverr_d;
            w_decerr_q <= w_decerr_d;
            b_resp_q   <= b_resp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_w_strb_i[i]) begin
                    mem_q[word_idx(aw_addr_q)][8*i +: 8] <= axi_w_data_i[8*i +: 8];
                end
            end
        end
    end

    assign axi_aw_ready_o = (w_state_q == W_IDLE);
    assign axi_w_ready_o  = (w_state_q == W_DATA);
    assign axi_b_valid_o  = (w_state_q == W_RESP);
    assign axi_b_resp_o   = b_resp_q;

    // -----------------------------------------------------------------------
    // Read channel
    // -----------------------------------------------------------------------
    r_state_t                  r_state_q, r_state_d;
    addr_t                     ar_addr_q, ar_addr_d;
    logic [7:0]                ar_len_q, ar_len_d;
    logic [1:0]                ar_burst_q, ar_burst_d;
    logic                      ar_bad_q, ar_bad_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]                r_resp_q, r_resp_d;
    logic                      r_last_q, r_last_d;
    logic                      ar_bad_in;
    addr_t                     rd_addr;
    logic                      rd_in_range;
    logic [AXI_DATA_WIDTH-1:0] rd_data;

    // Address of the word the next registered load would fetch: the start
    // address when idle, otherwise the successor of the current beat.
    always_comb begin
        ar_bad_in = bad_burst(axi_ar_len_i, axi_ar_burst_i, axi_ar_size_i);
        if (r_state_q == R_IDLE) begin
            rd_addr = axi_ar_addr_i;
        end else begin
            rd_addr = next_addr(ar_addr_q, ar_len_q, ar_burst_q, ar_bad_q);
        end
    end

    // Combinational array read: a same-edge write is not yet visible, so the
    // loaded word is the pre-write value.
    assign rd_in_range = in_range(rd_addr);
    assign rd_data     = rd_in_range ? mem_q[word_idx(rd_addr)] : '0;

    always_comb begin
        r_state_d  = r_state_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_burst_d = ar_burst_q;
        ar_bad_d   = ar_bad_q;
        r_cnt_d    = r_cnt_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_last_d   = r_last_q;

        case (r_state_q)
            R_IDLE: begin
                if (axi_ar_valid_i) begin
                    ar_addr_d  = axi_ar_addr_i;
                    ar_len_d   = axi_ar_len_i;
                    ar_burst_d = axi_ar_burst_i;
                    ar_bad_d   = ar_bad_in;
                    r_cnt_d    = 8'd0;
                    r_data_d   = rd_data;
                    r_resp_d   = !rd_in_range ? RESP_DECERR :
                                 ar_bad_in    ? RESP_SLVERR : RESP_OKAY;
                    r_last_d   = (axi_ar_len_i == 8'd0);
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_r_ready_i) begin
                    if (r_last_q) begin
                        r_last_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        ar_addr_d = rd_addr;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_data_d  = rd_data;
                        r_resp_d  = !rd_in_range ? RESP_DECERR :
                                    ar_bad_q     ? RESP_SLVERR : RESP_OKAY;
                        r_last_d  = ((r_cnt_q + 8'd1) == ar_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
            ar_bad_q   <= 1'b0;
            r_cnt_q    <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_last_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_burst_q <= ar_burst_d;
            ar_bad_q   <= ar_bad_d;
            r_cnt_q    <= r_cnt_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
        end
    end

    assign axi_ar_ready_o = (r_state_q == R_IDLE);
    assign axi_r_valid_o  = (r_state_q == R_DATA);
    assign axi_r_data_o   = r_data_q;
    assign axi_r_resp_o   = r_resp_q;
    assign axi_r_last_o   = r_last_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Drives write and read bursts into axi_sram_slave. Expected read beats are
// queued when a read is issued and compared against the beats the DUT
// returns; write responses and timing are compared inline per test.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axi_aw_valid_i, axi_aw_ready_o;
    logic [31:0] axi_aw_addr_i;
    logic [7:0]  axi_aw_len_i;
    logic [2:0]  axi_aw_size_i;
    logic [1:0]  axi_aw_burst_i;
    logic        axi_w_valid_i, axi_w_ready_o;
    logic [63:0] axi_w_data_i;
    logic [7:0]  axi_w_strb_i;
    logic        axi_w_last_i;
    logic        axi_b_valid_o, axi_b_ready_i;
    logic [1:0]  axi_b_resp_o;
    logic        axi_ar_valid_i, axi_ar_ready_o;
    logic [31:0] axi_ar_addr_i;
    logic [7:0]  axi_ar_len_i;
    logic [2:0]  axi_ar_size_i;
    logic [1:0]  axi_ar_burst_i;
    logic        axi_r_valid_o, axi_r_ready_i;
    logic [63:0] axi_r_data_o;
    logic [1:0]  axi_r_resp_o;
    logic        axi_r_last_o;

    int checks = 0;
    int errors = 0;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [63:0] wr_data[$];
    logic [7:0]  wr_strb[$];
    bit          rdy_pat[$];
    int          stall_viol;
    int          rd_lat;
    int          rd_cycles;
    logic        rvalid_after;

    axi_sram_slave dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi_aw_valid_i (axi_aw_valid_i),
        .axi_aw_ready_o (axi_aw_ready_o),
        .axi_aw_addr_i  (axi_aw_addr_i),
        .axi_aw_len_i   (axi_aw_len_i),
        .axi_aw_size_i  (axi_aw_size_i),
        .axi_aw_burst_i (axi_aw_burst_i),
        .axi_w_valid_i  (axi_w_valid_i),
        .axi_w_ready_o  (axi_w_ready_o),
        .axi_w_data_i   (axi_w_data_i),
        .axi_w_strb_i   (axi_w_strb_i),
        .axi_w_last_i   (axi_w_last_i),
        .axi_b_valid_o  (axi_b_valid_o),
        .axi_b_ready_i  (axi_b_ready_i),
        .axi_b_resp_o   (axi_b_resp_o),
        .axi_ar_valid_i (axi_ar_valid_i),
        .axi_ar_ready_o (axi_ar_ready_o),
        .axi_ar_addr_i  (axi_ar_addr_i),
        .axi_ar_len_i   (axi_ar_len_i),
        .axi_ar_size_i  (axi_ar_size_i),
        .axi_ar_burst_i (axi_ar_burst_i),
        .axi_r_valid_o  (axi_r_valid_o),
        .axi_r_ready_i  (axi_r_ready_i),
        .axi_r_data_o   (axi_r_data_o),
        .axi_r_resp_o   (axi_r_resp_o),
        .axi_r_last_o   (axi_r_last_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
        beat_t b;
        b.data = d;
        b.resp = r;
        b.last = l;
        return b;
    endfunction

    // Drives one write burst from wr_data/wr_strb. w_last is raised on beat
    // last_at only (-1: never). Returns the B response and how many cycles
    // after the final W handshake b_valid was first seen (0 = next cycle).
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int last_at, output logic [1:0] resp,
                             output int b_lat);
        int n;
        axi_aw_addr_i  = addr;
        axi_aw_len_i   = len;
        axi_aw_size_i  = size;
        axi_aw_burst_i = burst;
        axi_aw_valid_i = 1'b1;
        n = 0;
        while (!axi_aw_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL aw_timeout: aw_ready stayed %b, required 1", axi_aw_ready_o);
        end
        @(posedge clk); #1;
        axi_aw_valid_i = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_w_valid_i = 1'b1;
            axi_w_data_i  = (i < wr_data.size()) ? wr_data[i] : 64'h0;
            axi_w_strb_i  = (i < wr_strb.size()) ? wr_strb[i] : 8'hFF;
            axi_w_last_i  = (i == last_at);
            n = 0;
            while (!axi_w_ready_o && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) begin
                checks++; errors++;
                $display("FAIL w_timeout: w_ready stayed %b on beat %0d, required 1", axi_w_ready_o, i);
            end
            @(posedge clk); #1;
        end
        axi_w_valid_i = 1'b0;
        axi_w_last_i  = 1'b0;
        axi_b_ready_i = 1'b1;
        b_lat = 0;
        while (!axi_b_valid_o && b_lat < 100) begin @(posedge clk); #1; b_lat++; end
        if (b_lat >= 100) begin
            checks++; errors++;
            $display("FAIL b_timeout: b_valid stayed %b, required 1", axi_b_valid_o);
        end
        resp = axi_b_resp_o;
        @(posedge clk); #1;
        axi_b_ready_i = 1'b0;
        wr_data.delete();
        wr_strb.delete();
    endtask

    // Issues one read burst and records accepted beats into obs_q. r_ready
    // follows rdy_pat (all ones if empty). Reports stalls where the held beat
    // changed, the cycles until the first beat, and total cycles used.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int    n, cyc, beats, pi;
        bit    rdy, stalled, seen;
        beat_t cur, prev;
        axi_ar_addr_i  = addr;
        axi_ar_len_i   = len;
        axi_ar_size_i  = size;
        axi_ar_burst_i = burst;
        axi_ar_valid_i = 1'b1;
        n = 0;
        while (!axi_ar_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL ar_timeout: ar_ready stayed %b, required 1", axi_ar_ready_o);
        end
        @(posedge clk); #1;
        axi_ar_valid_i = 1'b0;
        cyc = 0; beats = 0; pi = 0; stalled = 1'b0; seen = 1'b0;
        rd_lat = 0; stall_viol = 0;
        prev = '0;
        while (beats < int'(len) + 1 && cyc < 3000) begin
            if (axi_r_valid_o) begin
                seen = 1'b1;
                cur  = mk_beat(axi_r_data_o, axi_r_resp_o, axi_r_last_o);
                if (stalled && cur !== prev) stall_viol++;
                rdy = (rdy_pat.size() == 0) ? 1'b1 : rdy_pat[pi % rdy_pat.size()];
                pi++;
                axi_r_ready_i = rdy;
                if (rdy) begin
                    obs_q.push_back(cur);
                    beats++;
                end
                stalled = !rdy;
                prev    = cur;
            end else begin
                axi_r_ready_i = 1'b0;
                if (!seen) rd_lat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL r_timeout: got %0d beats, required %0d", beats, int'(len) + 1);
        end
        axi_r_ready_i = 1'b0;
        rvalid_after  = axi_r_valid_o;
        rd_cycles     = cyc;
        rdy_pat.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        axi_aw_valid_i = 0; axi_aw_addr_i = 0; axi_aw_len_i = 0; axi_aw_size_i = 3; axi_aw_burst_i = 1;
        axi_w_valid_i = 0; axi_w_data_i = 0; axi_w_strb_i = 0; axi_w_last_i = 0; axi_b_ready_i = 0;
        axi_ar_valid_i = 0; axi_ar_addr_i = 0; axi_ar_len_i = 0; axi_ar_size_i = 3; axi_ar_burst_i = 1;
        axi_r_ready_i = 0;
        #12;
        checks++;
        if ({axi_aw_ready_o, axi_ar_ready_o, axi_w_ready_o, axi_b_valid_o, axi_r_valid_o, axi_r_last_o} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_handshake: aw_rdy,ar_rdy,w_rdy,b_vld,r_vld,r_last=%b, required 110000",
                     {axi_aw_ready_o, axi_ar_ready_o, axi_w_ready_o, axi_b_valid_o, axi_r_valid_o, axi_r_last_o});
        end
        checks++;
        if ({axi_b_resp_o, axi_r_resp_o, axi_r_data_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_data: b_resp=%b r_resp=%b r_data=%h, required all zero",
                     axi_b_resp_o, axi_r_resp_o, axi_r_data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        wr_data.push_back(64'h1122334455667788); wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0010, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b, required 00", resp); end
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL single_blat: b_valid after %0d extra cycles, required 0", lat); end
        checks++;
        if (axi_aw_ready_o !== 1'b1) begin errors++; $display("FAIL single_aw_reopen: aw_ready=%b after B, required 1", axi_aw_ready_o); end

        exp_q.push_back(mk_beat(64'h1122334455667788, 2'b00, 1'b1));
        axi_read(32'h8000_0010, 8'd0, 2'b01, 3'd3);
        checks++;
        if (rd_lat !== 0) begin errors++; $display("FAIL single_rlat: r_valid after %0d extra cycles, required 0", rd_lat); end
        checks++;
        if (rvalid_after !== 1'b0) begin errors++; $display("FAIL single_rdrop: r_valid=%b after last, required 0", rvalid_after); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL single_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_incr_stall();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        for (int i = 0; i < 4; i++) begin
            wr_data.push_back(64'hA000_0000_0000_0000 + 64'(i)); wr_strb.push_back(8'hFF);
        end
        axi_write(32'h8000_0100, 8'd3, 2'b01, 3'd3, 3, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b, required 00", resp); end

        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk_beat(64'hA000_0000_0000_0000 + 64'(i), 2'b00, i == 3));
        rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0); rdy_pat.push_back(1);
        axi_read(32'h8000_0100, 8'd3, 2'b01, 3'd3);
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL incr_stall_hold: %0d changed beats during stall, required 0", stall_viol); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL incr_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL incr_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_partial();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        wr_data.push_back(64'hFFFF_FFFF_FFFF_FFFF); wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0020, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        wr_data.push_back(64'h0000_0000_DEAD_BEEF); wr_strb.push_back(8'h0F);
        axi_write(32'h8000_0020, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL partial_bresp: got %b, required 00", resp); end
        exp_q.push_back(mk_beat(64'hFFFF_FFFF_DEAD_BEEF, 2'b00, 1'b1));
        axi_read(32'h8000_0020, 8'd0, 2'b01, 3'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL partial_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL partial_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    // Relies on words 0x100..0x118 holding A0..A3 from test_incr_stall.
    task automatic test_bursts();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        // WRAP len=3 from 0x118: 118,100,108,110
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0003, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0000, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0001, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0002, 2'b00, 1'b1));
        axi_read(32'h8000_0118, 8'd3, 2'b10, 3'd3);
        checks++;
        if (rd_cycles !== 4) begin errors++; $display("FAIL wrap_throughput: %0d cycles for 4 beats, required 4", rd_cycles); end
        // WRAP len=2 is illegal: SLVERR on every beat, stepping as INCR
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0000, 2'b10, 1'b0));
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0001, 2'b10, 1'b0));
        exp_q.push_back(mk_beat(64'hA000_0000_0000_0002, 2'b10, 1'b1));
        axi_read(32'h8000_0100, 8'd2, 2'b10, 3'd3);
        // FIXED write of three beats lands on one word; FIXED read repeats it
        wr_data.push_back(64'h111); wr_data.push_back(64'h222); wr_data.push_back(64'h333);
        repeat (3) wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0300, 8'd2, 2'b00, 3'd3, 2, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp: got %b, required 00", resp); end
        exp_q.push_back(mk_beat(64'h333, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'h333, 2'b00, 1'b1));
        axi_read(32'h8000_0300, 8'd1, 2'b00, 3'd3);
        exp_q.push_back(mk_beat(64'h0, 2'b00, 1'b0));
        axi_read(32'h8000_0308, 8'd0, 2'b01, 3'd3);
        exp_q.pop_back();
        obs_q.pop_back();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL burst_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL burst_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_errors();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        // 0x0000_1000 aliases word 0x200 (byte 0x8000_1000) if range gating is lost
        wr_data.push_back(64'hCAFE_CAFE_CAFE_CAFE); wr_strb.push_back(8'hFF);
        axi_write(32'h8000_1000, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        wr_data.push_back(64'hBAD0_BAD0_BAD0_BAD0); wr_strb.push_back(8'hFF);
        axi_write(32'h0000_1000, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b11) begin errors++; $display("FAIL oor_bresp: got %b, required 11", resp); end
        exp_q.push_back(mk_beat(64'hCAFE_CAFE_CAFE_CAFE, 2'b00, 1'b1));
        axi_read(32'h8000_1000, 8'd0, 2'b01, 3'd3);
        exp_q.push_back(mk_beat(64'h0, 2'b11, 1'b1));
        axi_read(32'h0000_1000, 8'd0, 2'b01, 3'd3);

        // w_last missing on the final beat
        wr_data.push_back(64'hC0); wr_data.push_back(64'hC1); repeat (2) wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0060, 8'd1, 2'b01, 3'd3, -1, resp, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL nolast_bresp: got %b, required 10", resp); end
        // w_last early: still two beats, both written
        wr_data.push_back(64'hE0); wr_data.push_back(64'hE1); repeat (2) wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0040, 8'd1, 2'b01, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL earlylast_bresp: got %b, required 10", resp); end
        exp_q.push_back(mk_beat(64'hE0, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'hE1, 2'b00, 1'b1));
        axi_read(32'h8000_0040, 8'd1, 2'b01, 3'd3);

        // Last word of memory: second beat runs off the end
        wr_data.push_back(64'h77); wr_data.push_back(64'h88); repeat (2) wr_strb.push_back(8'hFF);
        axi_write(32'h8000_1FF8, 8'd1, 2'b01, 3'd3, 1, resp, lat);
        checks++;
        if (resp !== 2'b11) begin errors++; $display("FAIL edge_bresp: got %b, required 11", resp); end
        exp_q.push_back(mk_beat(64'h77, 2'b00, 1'b0));
        exp_q.push_back(mk_beat(64'h0, 2'b11, 1'b1));
        axi_read(32'h8000_1FF8, 8'd1, 2'b01, 3'd3);

        // Illegal size on read, illegal burst type on write
        exp_q.push_back(mk_beat(64'h1122334455667788, 2'b10, 1'b1));
        axi_read(32'h8000_0010, 8'd0, 2'b01, 3'd4);
        wr_data.push_back(64'h55); wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0050, 8'd0, 2'b11, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b10) begin errors++; $display("FAIL badburst_bresp: got %b, required 10", resp); end
        // DECERR outranks SLVERR
        wr_data.push_back(64'h66); wr_strb.push_back(8'hFF);
        axi_write(32'h0000_0000, 8'd0, 2'b01, 3'd3, -1, resp, lat);
        checks++;
        if (resp !== 2'b11) begin errors++; $display("FAIL prio_bresp: got %b, required 11", resp); end

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL err_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL err_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_midburst();
        logic [1:0] resp;
        int         lat;
        beat_t      e, o;
        axi_aw_addr_i = 32'h8000_0200; axi_aw_len_i = 8'd7; axi_aw_size_i = 3'd3; axi_aw_burst_i = 2'b01;
        axi_ar_addr_i = 32'h8000_0100; axi_ar_len_i = 8'd7; axi_ar_size_i = 3'd3; axi_ar_burst_i = 2'b01;
        axi_aw_valid_i = 1'b1; axi_ar_valid_i = 1'b1;
        @(posedge clk); #1;
        axi_aw_valid_i = 1'b0; axi_ar_valid_i = 1'b0;
        axi_w_valid_i = 1'b1; axi_w_strb_i = 8'hFF; axi_w_data_i = 64'h1234; axi_w_last_i = 1'b0;
        axi_r_ready_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({axi_w_ready_o, axi_r_valid_o} !== 2'b11) begin
            errors++; $display("FAIL midburst_active: w_ready,r_valid=%b, required 11", {axi_w_ready_o, axi_r_valid_o});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({axi_aw_ready_o, axi_ar_ready_o, axi_w_ready_o, axi_b_valid_o, axi_r_valid_o, axi_r_last_o} !== 6'b110000) begin
            errors++;
            $display("FAIL midburst_reset: aw_rdy,ar_rdy,w_rdy,b_vld,r_vld,r_last=%b, required 110000",
                     {axi_aw_ready_o, axi_ar_ready_o, axi_w_ready_o, axi_b_valid_o, axi_r_valid_o, axi_r_last_o});
        end
        axi_w_valid_i = 1'b0; axi_r_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        wr_data.push_back(64'h5A5A_5A5A_0F0F_0F0F); wr_strb.push_back(8'hFF);
        axi_write(32'h8000_0208, 8'd0, 2'b01, 3'd3, 0, resp, lat);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL post_reset_bresp: got %b, required 00", resp); end
        exp_q.push_back(mk_beat(64'h5A5A_5A5A_0F0F_0F0F, 2'b00, 1'b1));
        axi_read(32'h8000_0208, 8'd0, 2'b01, 3'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL post_reset_beat: got no beat, required %h/%b/%b", e.data, e.resp, e.last);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL post_reset_beat: got %h/%b/%b, required %h/%b/%b", o.data, o.resp, o.last, e.data, e.resp, e.last);
                end
            end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr_stall();
        test_partial();
        test_bursts();
        test_errors();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
